scan_ram: RTL and testbench

- Parametrised successor to the lab's single-port 32x3 switch-driven RAM.
- Simple dual-port memory with three mechanisms:
  - an independent write port;
  - a free-running read port that auto-scans every address at a programmable rate;
  - a hardware clear sequencer that zeroes the array after every reset.
- Sits between the DE1_SoC switch/key inputs and the HEX display driver. The scan address and read data feed the display; the write port is driven from SW.

---
 rtl/scan_ram_pkg.sv | 14 +
 rtl/scan_ram_if.sv | 27 ++
 rtl/sdp_ram_core.sv | 44 ++++
 rtl/scan_ram.sv | 105 ++++++++++
 tb/tb_scan_ram.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_ram_pkg.sv
// Shared types and helpers for the scanning display RAM.
package scan_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } scan_state_t;

   // Counter width for a modulus of n; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scan_ram_if.sv
// Write port, scan control and display read-out of scan_ram.
interface scan_ram_if #(
   parameter int DATA_W = 3,
   parameter int DEPTH  = 32
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              scan_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              rd_valid;

   modport master (
      output wr_en, wr_addr, wr_data, scan_en,
      input  rd_addr, rd_data, busy, rd_valid
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, scan_en,
      output rd_addr, rd_data, busy, rd_valid
   );

endinterface

// File: rtl/sdp_ram_core.sv
// Simple dual-port RAM: one write port, one registered write-first read port.
module sdp_ram_core #(
   parameter int DATA_W = 3,
   parameter int DEPTH  = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_d;
   logic [DATA_W-1:0] rdata_q;

   // A same-cycle write to the read address is forwarded to the output.
   always_comb begin
      rdata_d = mem[raddr];
      if (we && (waddr == raddr)) begin
         rdata_d = wdata;
      end
   end

   // NOTE: the array has no reset so it maps onto block RAM; only the output register clears.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/scan_ram.sv
// Display RAM: clears itself after reset, then auto-scans every word at a programmable rate.
module scan_ram
   import scan_ram_pkg::*;
#(
   parameter int DATA_W   = 3,
   parameter int DEPTH    = 32,
   parameter int SCAN_DIV = 50_000_000
) (
   input  logic      clk,
   input  logic      reset_n,
   scan_ram_if.slave bus
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int DIV_W  = cnt_w(SCAN_DIV);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(SCAN_DIV - 1);
   // One bit wider so DEPTH itself is representable when it is a power of two.
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   scan_state_t       state_q, state_d;
   logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic              rd_valid_q, rd_valid_d;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      clear_ptr_d = clear_ptr_q;
      rd_addr_d   = rd_addr_q;
      div_cnt_d   = div_cnt_q;
      rd_valid_d  = 1'b0;
      ram_we      = 1'b0;
      ram_waddr   = bus.wr_addr;
      ram_wdata   = bus.wr_data;

      case (state_q)
         CLEAR: begin
            // The sequencer owns the write port; external writes are dropped.
            ram_we    = 1'b1;
            ram_waddr = clear_ptr_q;
            ram_wdata = '0;
            if (clear_ptr_q == LAST_ADDR) begin
               state_d = RUN;
            end else begin
               clear_ptr_d = clear_ptr_q + 1'b1;
            end
         end

         RUN: begin
            rd_valid_d = 1'b1;
            ram_we     = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_EXT);
            if (bus.scan_en) begin
               if (div_cnt_q == LAST_DIV) begin
                  div_cnt_d = '0;
                  rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
               end else begin
                  div_cnt_d = div_cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= CLEAR;
         clear_ptr_q <= '0;
         rd_addr_q   <= '0;
         div_cnt_q   <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         clear_ptr_q <= clear_ptr_d;
         rd_addr_q   <= rd_addr_d;
         div_cnt_q   <= div_cnt_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   sdp_ram_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (ram_we),
      .waddr   (ram_waddr),
      .wdata   (ram_wdata),
      .raddr   (rd_addr_q),
      .rdata   (bus.rd_data)
   );

   assign bus.rd_addr  = rd_addr_q;
   assign bus.busy     = (state_q == CLEAR);
   assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_scan_ram.sv
// Randomised self-checking bench for scan_ram: a 32-word/div-4 instance against a
// reference model, and a 20-word/div-1 instance for non-power-of-two depth.
module tb_scan_ram;

   localparam int DW      = 3;
   localparam int A_DEPTH = 32;
   localparam int A_DIV   = 4;
   localparam int B_DEPTH = 20;
   localparam int B_DIV   = 1;

   logic clk     = 1'b0;
   logic rst_a_n = 1'b1;
   logic rst_b_n = 1'b1;

   int errors = 0;
   int checks = 0;

   scan_ram_if #(.DATA_W(DW), .DEPTH(A_DEPTH)) bus_a ();
   scan_ram_if #(.DATA_W(DW), .DEPTH(B_DEPTH)) bus_b ();

   scan_ram #(.DATA_W(DW), .DEPTH(A_DEPTH), .SCAN_DIV(A_DIV)) dut_a (
      .clk     (clk),
      .reset_n (rst_a_n),
      .bus     (bus_a.slave)
   );

   scan_ram #(.DATA_W(DW), .DEPTH(B_DEPTH), .SCAN_DIV(B_DIV)) dut_b (
      .clk     (clk),
      .reset_n (rst_b_n),
      .bus     (bus_b.slave)
   );

   always #5 clk = ~clk;

   // Reference model of instance A: memory array, clear progress and a count of scan-enabled run cycles.
   logic [DW-1:0] m_mem [A_DEPTH];
   int            m_steps;
   int            m_clear_cnt;
   bit            m_run;
   bit            m_valid;
   logic [DW-1:0] m_rd;
   logic [4:0]    m_addr;

   always @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         m_steps     = 0;
         m_clear_cnt = 0;
         m_run       = 1'b0;
         m_valid     = 1'b0;
         m_rd        = '0;
         m_addr      = '0;
      end else begin
         m_valid = m_run;
         if (!m_run) begin
            m_mem[m_clear_cnt] = '0;
            m_clear_cnt++;
            if (m_clear_cnt == A_DEPTH) m_run = 1'b1;
         end else begin
            if (bus_a.wr_en && int'(bus_a.wr_addr) < A_DEPTH) m_mem[bus_a.wr_addr] = bus_a.wr_data;
            if (bus_a.scan_en) m_steps++;
         end
         m_rd   = m_mem[m_addr];
         m_addr = 5'((m_steps / A_DIV) % A_DEPTH);
      end
   end

   task automatic wait_clear_a(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus_a.busy === 1'b1 && n < 200);
   endtask

   task automatic check_reset_values_a(input string tag);
      checks++;
      if (bus_a.rd_addr !== 5'd0) begin errors++; $display("FAIL %s_rd_addr: got %0d want 0", tag, bus_a.rd_addr); end
      checks++;
      if (bus_a.rd_data !== 3'd0) begin errors++; $display("FAIL %s_rd_data: got %0d want 0", tag, bus_a.rd_data); end
      checks++;
      if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b want 1", tag, bus_a.busy); end
      checks++;
      if (bus_a.rd_valid !== 1'b0) begin errors++; $display("FAIL %s_rd_valid: got %b want 0", tag, bus_a.rd_valid); end
   endtask

   task automatic test_reset;
      int n;
      @(negedge clk);
      rst_a_n = 1'b0;
      #1;
      check_reset_values_a("por");
      repeat (3) @(negedge clk);
      rst_a_n = 1'b1;
      wait_clear_a(n);
      checks++;
      if (n !== A_DEPTH) begin errors++; $display("FAIL first_clear_len: got %0d want %0d", n, A_DEPTH); end
      checks++;
      if (bus_a.rd_valid !== 1'b0) begin errors++; $display("FAIL valid_first_run: got %b want 0", bus_a.rd_valid); end
      // Preload every word with all ones so the second clear has something to erase.
      for (int a = 0; a < A_DEPTH; a++) begin
         bus_a.wr_en   = 1'b1;
         bus_a.wr_addr = 5'(a);
         bus_a.wr_data = 3'b111;
         @(negedge clk);
         if (a == 0) begin
            checks++;
            if (bus_a.rd_valid !== 1'b1) begin errors++; $display("FAIL valid_rise: got %b want 1", bus_a.rd_valid); end
         end
      end
      bus_a.wr_en = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_a.rd_data !== 3'b111 || bus_a.rd_data !== m_rd) begin
         errors++; $display("FAIL preload_read: got %0d want 7", bus_a.rd_data);
      end
      rst_a_n = 1'b0;
      #1;
      check_reset_values_a("rst_pulse");
      repeat (3) @(negedge clk);
      rst_a_n       = 1'b1;
      bus_a.wr_en   = 1'b1;
      bus_a.wr_addr = 5'd5;
      bus_a.wr_data = 3'b111;
      wait_clear_a(n);
      bus_a.wr_en = 1'b0;
      checks++;
      if (n !== A_DEPTH) begin errors++; $display("FAIL clear_len: got %0d want %0d", n, A_DEPTH); end
      bus_a.scan_en = 1'b1;
      for (int i = 0; i < A_DEPTH * A_DIV; i++) begin
         @(negedge clk);
         checks++;
         if (bus_a.rd_data !== 3'd0) begin
            errors++; $display("FAIL cleared_word: addr=%0d got %0d want 0", (i / A_DIV), bus_a.rd_data);
         end
         checks++;
         if (bus_a.rd_addr !== m_addr) begin
            errors++; $display("FAIL clear_scan_addr: got %0d want %0d", bus_a.rd_addr, m_addr);
         end
      end
      bus_a.scan_en = 1'b0;
   endtask

   task automatic test_write_first;
      bus_a.wr_en   = 1'b1;
      bus_a.wr_addr = 5'd0;
      bus_a.wr_data = 3'b011;
      @(negedge clk);
      checks++;
      if (bus_a.rd_data !== 3'b011) begin errors++; $display("FAIL write_first: got %0d want 3", bus_a.rd_data); end
      bus_a.wr_addr = 5'd2;
      bus_a.wr_data = 3'b001;
      @(negedge clk);
      checks++;
      if (bus_a.rd_data !== 3'b011) begin errors++; $display("FAIL other_addr_write: got %0d want 3", bus_a.rd_data); end
      for (int i = 0; i < 24; i++) begin
         bus_a.wr_en   = 1'($urandom_range(1));
         bus_a.wr_addr = 5'($urandom_range(A_DEPTH - 1));
         bus_a.wr_data = 3'($urandom);
         @(negedge clk);
         checks++;
         if (bus_a.rd_data !== m_rd) begin
            errors++; $display("FAIL random_rw: got %0d want %0d", bus_a.rd_data, m_rd);
         end
      end
      bus_a.wr_en   = 1'b1;
      bus_a.wr_addr = 5'd2;
      bus_a.wr_data = 3'b001;
      @(negedge clk);
      bus_a.wr_en = 1'b0;
   endtask

   task automatic test_scan_wrap;
      logic [4:0] prev;
      int         last_chg;
      int         nchg;
      bit         wrapped;
      bit         saw_two;
      prev     = m_addr;
      last_chg = 0;
      nchg     = 0;
      wrapped  = 1'b0;
      saw_two  = 1'b0;
      bus_a.scan_en = 1'b1;
      for (int i = 0; i < A_DEPTH * A_DIV + 8; i++) begin
         bus_a.wr_en   = 1'($urandom_range(1));
         bus_a.wr_addr = 5'($urandom_range(A_DEPTH - 1));
         if (bus_a.wr_addr == 5'd2) bus_a.wr_addr = 5'd3;
         bus_a.wr_data = 3'($urandom);
         @(negedge clk);
         checks++;
         if (bus_a.rd_addr !== m_addr || bus_a.rd_data !== m_rd || bus_a.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL scan_model: addr %0d/%0d data %0d/%0d valid %b (got/want)",
                     bus_a.rd_addr, m_addr, bus_a.rd_data, m_rd, bus_a.rd_valid);
         end
         if (saw_two) begin
            checks++;
            if (bus_a.rd_data !== 3'b001) begin errors++; $display("FAIL addr2_data: got %0d want 1", bus_a.rd_data); end
            saw_two = 1'b0;
         end
         if (bus_a.rd_addr !== prev) begin
            if (nchg > 0) begin
               checks++;
               if (i - last_chg != A_DIV) begin
                  errors++; $display("FAIL scan_period: got %0d want %0d", i - last_chg, A_DIV);
               end
            end
            if (prev == 5'd31 && bus_a.rd_addr == 5'd0) wrapped = 1'b1;
            if (bus_a.rd_addr == 5'd2) saw_two = 1'b1;
            last_chg = i;
            nchg++;
            prev = bus_a.rd_addr;
         end
      end
      bus_a.wr_en = 1'b0;
      checks++;
      if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_31_0: got %b want 1", wrapped); end
   endtask

   task automatic test_freeze;
      int         n;
      logic [4:0] frozen;
      logic [2:0] d;
      n = 0;
      while ((m_steps % A_DIV) != 2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 20) begin errors++; $display("FAIL freeze_sync: got timeout want div_cnt=2"); end
      bus_a.scan_en = 1'b0;
      frozen = m_addr;
      for (int i = 0; i < 10; i++) begin
         d = 3'($urandom);
         bus_a.wr_en   = 1'b1;
         bus_a.wr_addr = frozen;
         bus_a.wr_data = d;
         @(negedge clk);
         checks++;
         if (bus_a.rd_addr !== frozen || bus_a.rd_data !== d) begin
            errors++;
            $display("FAIL freeze_hold: addr %0d/%0d data %0d/%0d (got/want)", bus_a.rd_addr, frozen, bus_a.rd_data, d);
         end
      end
      bus_a.wr_en   = 1'b0;
      bus_a.scan_en = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_a.rd_addr !== frozen) begin errors++; $display("FAIL resume_early: got %0d want %0d", bus_a.rd_addr, frozen); end
      @(negedge clk);
      checks++;
      if (bus_a.rd_addr !== 5'(frozen + 5'd1)) begin
         errors++; $display("FAIL resume_step: got %0d want %0d", bus_a.rd_addr, 5'(frozen + 5'd1));
      end
   endtask

   task automatic test_reset_mid_run;
      int n;
      n = 0;
      while (m_addr != 5'd7 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 400 || bus_a.rd_addr !== 5'd7) begin
         errors++; $display("FAIL reach_addr7: got %0d want 7", bus_a.rd_addr);
      end
      rst_a_n = 1'b0;
      #1;
      check_reset_values_a("mid_run");
      repeat (2) @(negedge clk);
      rst_a_n = 1'b1;
      wait_clear_a(n);
      checks++;
      if (n !== A_DEPTH) begin errors++; $display("FAIL reclear_len: got %0d want %0d", n, A_DEPTH); end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (bus_a.rd_data !== 3'd0 || bus_a.rd_addr !== m_addr) begin
            errors++;
            $display("FAIL post_reclear: addr %0d/%0d data %0d/0 (got/want)", bus_a.rd_addr, m_addr, bus_a.rd_data);
         end
      end
      bus_a.scan_en = 1'b0;
   endtask

   task automatic test_nonpow2;
      int         n;
      int         exp_addr;
      bit         wrapped;
      logic [4:0] prev;
      @(negedge clk);
      rst_b_n       = 1'b1;
      bus_b.wr_en   = 1'b1;
      bus_b.wr_addr = 5'd25;
      bus_b.wr_data = 3'b111;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus_b.busy === 1'b1 && n < 200);
      checks++;
      if (n !== B_DEPTH) begin errors++; $display("FAIL b_clear_len: got %0d want %0d", n, B_DEPTH); end
      bus_b.scan_en = 1'b1;
      exp_addr = 0;
      wrapped  = 1'b0;
      prev     = '0;
      for (int i = 0; i < 2 * B_DEPTH + 5; i++) begin
         bus_b.wr_addr = (i == 0) ? 5'd25 : 5'(B_DEPTH + $urandom_range(31 - B_DEPTH));
         bus_b.wr_data = 3'($urandom | 1);
         @(negedge clk);
         exp_addr = (exp_addr + 1) % B_DEPTH;
         checks++;
         if (int'(bus_b.rd_addr) !== exp_addr || bus_b.rd_data !== 3'd0) begin
            errors++;
            $display("FAIL b_scan: addr %0d/%0d data %0d/0 (got/want)", bus_b.rd_addr, exp_addr, bus_b.rd_data);
         end
         if (prev == 5'd19 && bus_b.rd_addr == 5'd0) wrapped = 1'b1;
         prev = bus_b.rd_addr;
      end
      bus_b.wr_en = 1'b0;
      checks++;
      if (wrapped !== 1'b1) begin errors++; $display("FAIL b_wrap_19_0: got %b want 1", wrapped); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus_a.wr_en   = 1'b0;
      bus_a.wr_addr = '0;
      bus_a.wr_data = '0;
      bus_a.scan_en = 1'b0;
      bus_b.wr_en   = 1'b0;
      bus_b.wr_addr = '0;
      bus_b.wr_data = '0;
      bus_b.scan_en = 1'b0;
      #1;
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      test_reset();
      test_write_first();
      test_scan_wrap();
      test_freeze();
      test_reset_mid_run();
      test_nonpow2();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
